// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IFU) and load/store (LSU).
// It carries one transaction at a time: grant, then request handshake, then response routed back to the owner.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ifu_req_valid,
    output logic                 ifu_req_ready,
    input  logic [WIDTH-1:0]     ifu_addr,
    output logic                 ifu_resp_valid,
    output logic [WIDTH-1:0]     ifu_rdata,

    input  logic                 lsu_req_valid,
    output logic                 lsu_req_ready,
    input  logic [WIDTH-1:0]     lsu_addr,
    input  logic                 lsu_wen,
    input  logic [WIDTH-1:0]     lsu_wdata,
    input  logic [WIDTH/8-1:0]   lsu_wmask,
    output logic                 lsu_resp_valid,
    output logic [WIDTH-1:0]     lsu_rdata,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [WIDTH-1:0]     mem_addr,
    output logic                 mem_wen,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic [WIDTH/8-1:0]   mem_wmask,
    input  logic                 mem_resp_valid,
    input  logic [WIDTH-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

    state_t              state_r;
    logic                last_grant_r;
    logic                owner_r;
    logic                mem_req_valid_r;
    logic [WIDTH-1:0]    mem_addr_r;
    logic                mem_wen_r;
    logic [WIDTH-1:0]    mem_wdata_r;
    logic [WIDTH/8-1:0]  mem_wmask_r;

    logic                grant_s;
    logic                winner_s;
    logic                resp_fire_s;

    // Idle-state arbitration; on a tie the requester not served last time wins.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = GNT_IFU;
        if ((state_r == S_IDLE) && !rst) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_s  = 1'b1;
                winner_s = ~last_grant_r;
            end else if (lsu_req_valid) begin
                grant_s  = 1'b1;
                winner_s = GNT_LSU;
            end else if (ifu_req_valid) begin
                grant_s  = 1'b1;
                winner_s = GNT_IFU;
            end else begin
                grant_s  = 1'b0;
                winner_s = GNT_IFU;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = GNT_IFU;
        end
    end

    // Ready and response pulses are combinational; reset suppresses them, even mid-transaction.
    always_comb begin
        resp_fire_s    = (state_r == S_RESP) && mem_resp_valid && !rst;
        ifu_req_ready  = grant_s && (winner_s == GNT_IFU);
        lsu_req_ready  = grant_s && (winner_s == GNT_LSU);
        ifu_resp_valid = resp_fire_s && (owner_r == GNT_IFU);
        lsu_resp_valid = resp_fire_s && (owner_r == GNT_LSU);
        ifu_rdata      = mem_rdata;
        lsu_rdata      = mem_rdata;
    end

    // Transaction FSM: latches the winner's request and holds it stable until memory accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            last_grant_r    <= GNT_IFU;
            owner_r         <= GNT_IFU;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= {WIDTH{1'b0}};
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= {WIDTH{1'b0}};
            mem_wmask_r     <= {(WIDTH/8){1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_s) begin
                        state_r         <= S_REQ;
                        owner_r         <= winner_s;
                        last_grant_r    <= winner_s;
                        mem_req_valid_r <= 1'b1;
                        if (winner_s == GNT_LSU) begin
                            mem_addr_r  <= lsu_addr;
                            mem_wen_r   <= lsu_wen;
                            mem_wdata_r <= lsu_wdata;
                            mem_wmask_r <= lsu_wmask;
                        end else begin
                            // Fetches never write memory.
                            mem_addr_r  <= ifu_addr;
                            mem_wen_r   <= 1'b0;
                            mem_wdata_r <= {WIDTH{1'b0}};
                            mem_wmask_r <= {(WIDTH/8){1'b0}};
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        state_r         <= S_RESP;
                        mem_req_valid_r <= 1'b0;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_RESP: begin
                    if (mem_resp_valid) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                default: begin
                    state_r         <= S_IDLE;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wen       = mem_wen_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requesters, round-robin ties, back-pressure,
// spurious responses and reset during a pending response.
module tb_mem_arbiter;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               ifu_req_valid;
    logic               ifu_req_ready;
    logic [WIDTH-1:0]   ifu_addr;
    logic               ifu_resp_valid;
    logic [WIDTH-1:0]   ifu_rdata;
    logic               lsu_req_valid;
    logic               lsu_req_ready;
    logic [WIDTH-1:0]   lsu_addr;
    logic               lsu_wen;
    logic [WIDTH-1:0]   lsu_wdata;
    logic [WIDTH/8-1:0] lsu_wmask;
    logic               lsu_resp_valid;
    logic [WIDTH-1:0]   lsu_rdata;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [WIDTH-1:0]   mem_addr;
    logic               mem_wen;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH/8-1:0] mem_wmask;
    logic               mem_resp_valid;
    logic [WIDTH-1:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven afterwards and checked #1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();

        // Reset state, with requests present while reset is held
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        chk("rst_ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // IFU only
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        chk("ifu_grant_ready", {31'd0, ifu_req_ready}, 32'd1);
        chk("ifu_grant_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("ifu_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("ifu_mem_addr", mem_addr, 32'h8000_0000);
        chk("ifu_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("ifu_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        chk("ifu_resp_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd1);
        chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_resp_lsu_quiet", {31'd0, lsu_resp_valid}, 32'd0);
        tick();
        // Still high in idle: a spurious response must not pulse
        #1;
        chk("idle_spurious_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        chk("idle_spurious_req_valid", {31'd0, mem_req_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b0;

        // LSU store, with a spurious response while in S_REQ
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        chk("st_grant_ready", {31'd0, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0; lsu_addr = 32'h1111_2222; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_resp_valid = 1'b1;
        #1;
        chk("st_mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h8000_1000);
        chk("st_mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_mem_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
        chk("req_spurious_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("req_spurious_no_move", {31'd0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk("st_wait_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0;
        #1;
        chk("st_resp_pair", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd1);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk("st_resp_once", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);

        // Simultaneous requests after reset: LSU, IFU, LSU, IFU
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            #1;
            chk($sformatf("rr_ready_%0d", i), {30'd0, ifu_req_ready, lsu_req_ready},
                exp_lsu ? 32'd1 : 32'd2);
            tick();
            mem_req_ready = 1'b1;
            #1;
            chk($sformatf("rr_addr_%0d", i), mem_addr, exp_lsu ? 32'h0000_0200 : 32'h0000_0100);
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hA0 + i;
            #1;
            chk($sformatf("rr_resp_%0d", i), {30'd0, ifu_resp_valid, lsu_resp_valid},
                exp_lsu ? 32'd1 : 32'd2);
            chk($sformatf("rr_rdata_%0d", i), exp_lsu ? lsu_rdata : ifu_rdata, 32'hA0 + i);
            tick();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
        tick();

        // Back-pressure: address must stay latched while the IFU address moves
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        #1;
        chk("bp_grant", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd2);
        tick();
        for (int k = 0; k < 5; k++) begin
            ifu_addr = 32'h1234_0000 + k;
            #1;
            chk($sformatf("bp_valid_%0d", k), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("bp_addr_%0d", k), mem_addr, 32'h8000_0040);
            chk($sformatf("bp_quiet_%0d", k), {30'd0, ifu_resp_valid, ifu_req_ready}, 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        chk("bp_release_addr", mem_addr, 32'h8000_0040);
        tick();
        mem_req_ready = 1'b0; ifu_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h55;
        #1;
        chk("bp_resp", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd2);
        chk("bp_rdata", ifu_rdata, 32'h55);
        tick();
        mem_resp_valid = 1'b0;

        // Reset in S_RESP after an LSU grant (last_grant would otherwise favour IFU)
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0300;
        #1;
        chk("rr_pre_grant", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd1);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h77;
        #1;
        chk("rst_resp_suppressed", {30'd0, ifu_resp_valid, lsu_resp_valid}, 32'd0);
        tick();
        rst = 1'b0; mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        chk("post_rst_tie_lsu", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd1);
        chk("post_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("post_rst_mem_addr", mem_addr, 32'h0);
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
